// File: rtl/rst_sequencer.sv
// Reset sequencer: synchronises and debounces an external reset button, then
// releases NumDomains active-low reset domains in order after a hold period.
//
// state   | meaning
// --------+-----------------------------------------------------------
// HOLD    | all domains held in reset, counting HoldCycles
// RELEASE | domains released one by one, StaggerCycles apart
// RUN     | all domains released, done_o high
module rst_sequencer #(
  parameter int NumDomains     = 3,
  parameter int HoldCycles     = 195,
  parameter int StaggerCycles  = 16,
  parameter int DebounceCycles = 1000
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_sys_i,
  input  logic                  nrst_i,
  input  logic                  soft_rst_req_i,
  output logic [NumDomains-1:0] rst_n_o,
  output logic                  done_o,
  output logic                  busy_o
);

  localparam int MaxStep = (HoldCycles > StaggerCycles) ? HoldCycles : StaggerCycles;
  localparam int CntW    = (MaxStep > 1) ? $clog2(MaxStep) : 1;
  localparam int DebW    = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_RUN
  } state_e;

  logic                  sync1_q, sync1_d;
  logic                  sync2_q, sync2_d;
  logic                  deb_q, deb_d;
  logic [DebW-1:0]       deb_cnt_q, deb_cnt_d;
  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NumDomains-1:0] rst_n_q, rst_n_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  trigger;

  always_comb begin
    sync1_d   = nrst_i;
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_cnt_d = '0;
    // A matching sample leaves the counter cleared; the level only flips on
    // the DebounceCycles-th consecutive differing sample.
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DebW'(DebounceCycles - 1)) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end

    trigger = soft_rst_req_i | (deb_q & ~deb_d);

    state_d = state_q;
    cnt_d   = cnt_q;
    rst_n_d = rst_n_q;
    done_d  = done_q;
    busy_d  = busy_q;

    if (trigger) begin
      state_d = ST_HOLD;
      cnt_d   = '0;
      rst_n_d = '0;
      done_d  = 1'b0;
      busy_d  = 1'b1;
    end else begin
      case (state_q)
        ST_HOLD: begin
          // Button still held: hold timing starts only once it is released.
          if (!deb_q) begin
            cnt_d = '0;
          end else if (cnt_q == CntW'(HoldCycles - 1)) begin
            cnt_d   = '0;
            rst_n_d = NumDomains'(1);
            state_d = ST_RELEASE;
            if (&rst_n_d) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == CntW'(StaggerCycles - 1)) begin
            cnt_d   = '0;
            rst_n_d = (rst_n_q << 1) | NumDomains'(1);
            if (&rst_n_d) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          state_d = ST_RUN;
        end
        default: begin
          state_d = ST_HOLD;
          cnt_d   = '0;
          rst_n_d = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (rst_sys_i) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
      state_q   <= ST_HOLD;
      cnt_q     <= '0;
      rst_n_q   <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b1;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_n_q   <= rst_n_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign rst_n_o = rst_n_q;
  assign done_o  = done_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench for rst_sequencer: expected output transitions are queued
// with their cycle stamps and matched by a monitor on every output change.
module tb_rst_sequencer;

  localparam int NumDomains     = 3;
  localparam int HoldCycles     = 4;
  localparam int StaggerCycles  = 2;
  localparam int DebounceCycles = 3;

  typedef struct {
    int         cyc;
    logic [2:0] rst_n;
    logic       done;
    logic       busy;
  } ev_t;

  logic                  clk_sys_i = 1'b0;
  logic                  rst_sys_i;
  logic                  nrst_i;
  logic                  soft_rst_req_i;
  logic [NumDomains-1:0] rst_n_o;
  logic                  done_o;
  logic                  busy_o;

  int  cyc = 0;
  int  n_checks = 0;
  int  n_fail = 0;
  ev_t exp_q[$];

  rst_sequencer #(
    .NumDomains    (NumDomains),
    .HoldCycles    (HoldCycles),
    .StaggerCycles (StaggerCycles),
    .DebounceCycles(DebounceCycles)
  ) dut (
    .clk_sys_i     (clk_sys_i),
    .rst_sys_i     (rst_sys_i),
    .nrst_i        (nrst_i),
    .soft_rst_req_i(soft_rst_req_i),
    .rst_n_o       (rst_n_o),
    .done_o        (done_o),
    .busy_o        (busy_o)
  );

  always #5 clk_sys_i = ~clk_sys_i;
  always @(posedge clk_sys_i) cyc <= cyc + 1;

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [2:0] r, input logic d, input logic b);
    ev_t e;
    e.cyc = c; e.rst_n = r; e.done = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  // Release pattern measured from the last edge that put the block in HOLD.
  task automatic push_release(input int t);
    push(t + 4, 3'b001, 1'b0, 1'b1);
    push(t + 6, 3'b011, 1'b0, 1'b1);
    push(t + 8, 3'b111, 1'b1, 1'b0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk_sys_i);
  endtask

  // Monitor: every change of the output bundle must match the next queued event.
  initial begin
    logic [4:0] prev;
    logic [4:0] cur;
    ev_t        e;
    prev = 'x;
    forever begin
      @(negedge clk_sys_i);
      cur = {rst_n_o, done_o, busy_o};
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_change: got %b expected no change (cycle %0d)", cur, cyc);
        end else begin
          e = exp_q.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("event_value", int'(cur), int'({e.rst_n, e.done, e.busy}));
        end
        prev = cur;
      end
    end
  end

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    int t;
    int t2;
    rst_sys_i      = 1'b1;
    nrst_i         = 1'b1;
    soft_rst_req_i = 1'b0;
    push(1, 3'b000, 1'b0, 1'b1);

    // Power-up: reset over edges 1..5, releases at 9/11/13.
    wait_until(5);
    rst_sys_i = 1'b0;
    push_release(5);
    wait_until(8);
    check("powerup_still_held", int'(rst_n_o), 0);
    check("powerup_busy", int'(busy_o), 1);
    wait_until(9);
    check("powerup_first_release", int'(rst_n_o), 1);
    wait_until(13);
    check("powerup_done", int'(done_o), 1);
    check("powerup_not_busy", int'(busy_o), 0);
    wait_until(16);

    // Two-cycle glitch must be rejected.
    nrst_i = 1'b0;
    @(negedge clk_sys_i);
    @(negedge clk_sys_i);
    nrst_i = 1'b1;
    wait_until(30);
    check("glitch_rst_n", int'(rst_n_o), 7);
    check("glitch_done", int'(done_o), 1);

    // Software request in RUN.
    c = cyc;
    soft_rst_req_i = 1'b1;
    t = c + 1;
    push(t, 3'b000, 1'b0, 1'b1);
    push_release(t);
    @(negedge clk_sys_i);
    soft_rst_req_i = 1'b0;
    check("soft_run_rst_n", int'(rst_n_o), 0);
    check("soft_run_busy", int'(busy_o), 1);
    wait_until(t + 12);

    // Software request while rst_n_o = 011 restarts the whole sequence.
    c = cyc;
    soft_rst_req_i = 1'b1;
    t = c + 1;
    push(t, 3'b000, 1'b0, 1'b1);
    push(t + 4, 3'b001, 1'b0, 1'b1);
    push(t + 6, 3'b011, 1'b0, 1'b1);
    @(negedge clk_sys_i);
    soft_rst_req_i = 1'b0;
    wait_until(t + 6);
    check("mid_seq_011", int'(rst_n_o), 3);
    soft_rst_req_i = 1'b1;
    t2 = t + 7;
    push(t2, 3'b000, 1'b0, 1'b1);
    push_release(t2);
    @(negedge clk_sys_i);
    soft_rst_req_i = 1'b0;
    wait_until(t2 + 12);

    // System reset together with a soft request while rst_n_o = 001.
    c = cyc;
    soft_rst_req_i = 1'b1;
    t = c + 1;
    push(t, 3'b000, 1'b0, 1'b1);
    push(t + 4, 3'b001, 1'b0, 1'b1);
    @(negedge clk_sys_i);
    soft_rst_req_i = 1'b0;
    wait_until(t + 4);
    check("pre_sysrst_001", int'(rst_n_o), 1);
    rst_sys_i      = 1'b1;
    soft_rst_req_i = 1'b1;
    push(t + 5, 3'b000, 1'b0, 1'b1);
    @(negedge clk_sys_i);
    soft_rst_req_i = 1'b0;
    check("sysrst_done", int'(done_o), 0);
    check("sysrst_busy", int'(busy_o), 1);
    @(negedge clk_sys_i);
    rst_sys_i = 1'b0;
    push_release(t + 6);
    wait_until(t + 18);

    // Button held 20 cycles: trigger after sync+debounce, release after debounce.
    c = cyc;
    nrst_i = 1'b0;
    push(c + 5, 3'b000, 1'b0, 1'b1);
    push_release(c + 25);
    wait_until(c + 20);
    check("button_held_rst_n", int'(rst_n_o), 0);
    nrst_i = 1'b1;
    wait_until(c + 26);
    check("button_still_held", int'(rst_n_o), 0);
    wait_until(c + 40);
    check("button_final_done", int'(done_o), 1);

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_sequencer.md
RST_SEQUENCER -- requirements
Module: rst_sequencer

Interface
REQ-001 SHALL have parameter NumDomains, default 3, number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter HoldCycles, default 195, cycles all domains stay asserted before the first release (>=1).
REQ-003 SHALL have parameter StaggerCycles, default 16, cycles between consecutive domain releases (>=1).
REQ-004 SHALL have parameter DebounceCycles, default 1000, consecutive stable samples required to accept a button change (>=1).
REQ-005 SHALL have port clk_sys_i  input  1  the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_sys_i  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port nrst_i  input  1  asynchronous active-low reset button.
REQ-008 SHALL have port soft_rst_req_i  input  1  synchronous single-cycle software reset request.
REQ-009 SHALL have port rst_n_o  output  NumDomains  per-domain active-low resets, registered.
REQ-010 SHALL have port done_o  output  1  all domains released (boot-ok), registered.
REQ-011 SHALL have port busy_o  output  1  sequence in progress (HOLD or RELEASE), registered.

Function
REQ-012 SHALL pass nrst_i through a 2-flop synchroniser, both flops resetting to 1.
REQ-013 SHALL debounce the synchroniser output: the debounced level (reset value 1) flips only after DebounceCycles consecutive samples differing from it; any matching sample clears the debounce counter.
REQ-014 SHALL implement states HOLD, RELEASE, RUN with a step counter sized for max(HoldCycles, StaggerCycles).
REQ-015 SHALL, in HOLD, keep rst_n_o all 0, done_o 0, busy_o 1, and count cycles; at count HoldCycles-1 it SHALL move to RELEASE and set rst_n_o[0] to 1.
REQ-016 SHALL hold the HOLD counter at 0 while the debounced button is 0, so release timing starts from button release.
REQ-017 SHALL, in RELEASE, set rst_n_o[k] to 1 exactly StaggerCycles cycles after rst_n_o[k-1]; bits once set stay set until a new trigger.
REQ-018 SHALL move to RUN and set done_o 1, busy_o 0 in the same cycle rst_n_o[NumDomains-1] rises; with NumDomains=1 this is the cycle rst_n_o[0] rises.
REQ-019 SHALL treat a debounced button falling to 0 or soft_rst_req_i=1 as a trigger in any state; on the next edge all rst_n_o SHALL be 0, done_o 0, busy_o 1, state HOLD, counter 0.
REQ-020 SHALL restart the full sequence on a trigger during HOLD or RELEASE (no partial continuation).
REQ-021 SHALL give soft_rst_req_i and button triggers equal effect when simultaneous; one trigger only.
REQ-022 SHALL never release domain k before domain k-1 and never assert domains out of order (all assert together).
REQ-023 SHALL have release time HoldCycles+k*StaggerCycles cycles after the first edge sampling rst_sys_i=0 for rst_n_o[k], with nrst_i high throughout.

Reset
REQ-024 SHALL, on rst_sys_i=1 at an edge, set state HOLD, counters 0, rst_n_o all 0, done_o 0, busy_o 1, synchroniser and debounced level 1.
REQ-025 SHALL apply rst_sys_i mid-sequence or in RUN identically to REQ-024, overriding any trigger in the same cycle.
REQ-026 SHALL have no asynchronous reset path; nrst_i affects state only through REQ-012/013.

Verification (NumDomains=3, HoldCycles=4, StaggerCycles=2, DebounceCycles=3)
REQ-027 SHALL check power-up: rst_sys_i high 5 cycles then low, nrst_i=1 -> rst_n_o 000 until cycle 4, 001 at 4, 011 at 6, 111 and done_o=1 at 8, busy_o=0 at 8.
REQ-028 SHALL check button press in RUN: nrst_i low 20 cycles -> rst_n_o 000 within 2+3+1 cycles of the fall; after nrst_i returns high and debounce (3+2 cycles) release repeats with 4/2/2 spacing.
REQ-029 SHALL check glitch rejection: nrst_i low 2 cycles in RUN -> rst_n_o stays 111, done_o stays 1.
REQ-030 SHALL check soft_rst_req_i pulse in RUN -> next edge rst_n_o 000, busy_o 1; sequence completes 8 cycles after the pulse edge.
REQ-031 SHALL check soft_rst_req_i pulse when rst_n_o=011 -> rst_n_o 000 next edge, full 4/2/2 sequence restarts.
REQ-032 SHALL check rst_sys_i asserted when rst_n_o=001 with soft_rst_req_i=1 same cycle -> REQ-024 values, then normal power-up timing.
